// File: rtl/gpio_input_ctrl_if.sv
// Data-bus port of the GPIO input peripheral: word-addressed register access
// with a registered one-cycle read response.
interface gpio_input_ctrl_if;
    logic [3:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output addr, re, we, wdata, input rdata, rvalid);
    modport slave  (input addr, re, we, wdata, output rdata, rvalid);
endinterface

// File: rtl/gpio_input_ctrl.sv
// Switch/push-button input peripheral: per-bit synchronizer and counter debouncer,
// change/press event capture, DATA/PEND/IRQ_EN register file and a level IRQ.
module gpio_input_ctrl #(
    parameter int unsigned N_SW      = 8,
    parameter int unsigned N_KEY     = 4,
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SW-1:0]    sw_in,
    input  logic [N_KEY-1:0]   key_in,
    gpio_input_ctrl_if.slave   bus,
    output logic               irq
);

    localparam int unsigned    NB      = N_SW + N_KEY;
    localparam int unsigned    CW      = $clog2(DB_CYCLES);
    localparam logic [NB-1:0]  RST_VAL = {{N_KEY{1'b1}}, {N_SW{1'b0}}};
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_PEND   = 2'd1,
        REG_IRQ_EN = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    // Internal bit order is {keys, switches}; the bus word puts keys at bit 16.
    function automatic logic [31:0] to_word(input logic [NB-1:0] v);
        logic [31:0] w;
        w               = '0;
        w[N_SW-1:0]     = v[N_SW-1:0];
        w[16 +: N_KEY]  = v[N_SW +: N_KEY];
        return w;
    endfunction

    function automatic logic [NB-1:0] from_word(input logic [31:0] w);
        return {w[16 +: N_KEY], w[N_SW-1:0]};
    endfunction

    logic [NB-1:0] w_pins;
    logic [NB-1:0] r_meta;
    logic [NB-1:0] r_sync;
    logic [NB-1:0] r_stable;
    logic [CW-1:0] r_cnt [NB];
    logic [NB-1:0] w_accept;
    logic [NB-1:0] w_set;
    logic [NB-1:0] w_clr;
    logic [NB-1:0] r_pend;
    logic [NB-1:0] r_irq_en;
    logic [31:0]   w_rd_word;
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic          r_irq;
    reg_sel_e      w_sel;
    logic          w_unused;

    assign w_pins   = {key_in, sw_in};
    assign w_sel    = reg_sel_e'(bus.addr[3:2]);
    assign w_unused = ^{bus.addr[1:0], bus.wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= w_pins;
            r_sync <= r_meta;
        end
    end

    always_comb begin
        w_accept = '0;
        w_set    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_accept[i] = (r_sync[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
            // Keys are active-low: only the accepted 1->0 transition is a press event.
            if (i < N_SW)
                w_set[i] = w_accept[i];
            else
                w_set[i] = w_accept[i] & ~r_sync[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= RST_VAL;
            for (int unsigned i = 0; i < NB; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= r_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_clr = (bus.we && (w_sel == REG_PEND)) ? from_word(bus.wdata) : '0;

    always_comb begin
        w_rd_word = '0;
        unique case (w_sel)
            REG_DATA:   w_rd_word = to_word({~r_stable[NB-1:N_SW], r_stable[N_SW-1:0]});
            REG_PEND:   w_rd_word = to_word(r_pend);
            REG_IRQ_EN: w_rd_word = to_word(r_irq_en);
            REG_RSVD:   w_rd_word = '0;
        endcase
    end

    // Set is OR-ed after the clear so a same-cycle event survives a W1C write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend   <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_pend   <= (r_pend & ~w_clr) | w_set;
            if (bus.we && (w_sel == REG_IRQ_EN))
                r_irq_en <= from_word(bus.wdata);
            r_irq    <= |(r_pend & r_irq_en);
            r_rvalid <= bus.re;
            if (bus.re)
                r_rdata <= w_rd_word;
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign irq        = r_irq;

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Self-checking bench for gpio_input_ctrl: directed scenarios with literal expectations,
// then random pin/bus traffic compared every cycle against a window-based reference model.
module tb_gpio_input_ctrl;

    localparam int unsigned N_SW  = 8;
    localparam int unsigned N_KEY = 4;
    localparam int unsigned DB    = 4;
    localparam logic [31:0] MASK  = 32'h000F_00FF;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] sw_in  = 8'h00;
    logic [3:0] key_in = 4'hF;
    logic       irq;

    gpio_input_ctrl_if bus ();

    gpio_input_ctrl #(
        .N_SW      (N_SW),
        .N_KEY     (N_KEY),
        .DB_CYCLES (DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .key_in (key_in),
        .bus    (bus.slave),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a bit's accepted level flips once the last DB samples seen
    // through the two-stage synchronizer all disagree with it.
    logic [7:0]  m_sw;
    logic [3:0]  m_key;
    logic [31:0] m_pend, m_en, m_rdata;
    logic        m_rvalid, m_irq;
    bit          m_valid = 0;
    logic [11:0] hist[$];

    initial begin
        logic [31:0] data_w, set_w, clr_w;
        logic [11:0] st, nst, smp;
        logic        irq_n, dif;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_sw = '0; m_key = '1; m_pend = '0; m_en = '0;
                m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
                hist.delete();
                for (int k = 0; k < int'(DB) + 2; k++) hist.push_back(12'hF00);
                m_valid = 1;
            end else begin
                data_w = {12'b0, ~m_key, 8'b0, m_sw};
                irq_n  = |(m_pend & m_en);
                if (bus.re) begin
                    case (bus.addr[3:2])
                        2'd0:    m_rdata = data_w;
                        2'd1:    m_rdata = m_pend;
                        2'd2:    m_rdata = m_en;
                        default: m_rdata = '0;
                    endcase
                end
                m_rvalid = bus.re;
                st  = {m_key, m_sw};
                nst = st;
                for (int b = 0; b < 12; b++) begin
                    dif = 1'b1;
                    for (int k = 2; k <= int'(DB) + 1; k++) begin
                        smp = hist[hist.size() - k];
                        if (smp[b] == st[b]) dif = 1'b0;
                    end
                    if (dif) nst[b] = ~st[b];
                end
                set_w        = '0;
                set_w[7:0]   = nst[7:0] ^ st[7:0];
                set_w[19:16] = st[11:8] & ~nst[11:8];
                clr_w  = (bus.we && bus.addr[3:2] == 2'd1) ? (bus.wdata & MASK) : '0;
                m_pend = (m_pend & ~clr_w) | set_w;
                if (bus.we && bus.addr[3:2] == 2'd2) m_en = bus.wdata & MASK;
                m_irq = irq_n;
                m_sw  = nst[7:0];
                m_key = nst[11:8];
                hist.push_back({key_in, sw_in});
                if (hist.size() > int'(DB) + 4) void'(hist.pop_front());
            end
            #1;
            if (m_valid) begin
                check("model rvalid", {31'b0, bus.rvalid}, {31'b0, m_rvalid});
                check("model rdata", bus.rdata, m_rdata);
                check("model irq", {31'b0, irq}, {31'b0, m_irq});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        bus.addr = a;
        bus.re   = 1'b1;
        @(posedge clk);
        #1;
        check(name, bus.rdata, exp);
        check({name, " rvalid"}, {31'b0, bus.rvalid}, 32'd1);
        @(negedge clk);
        bus.re = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    initial begin
        bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wdata = '0;
        idle(2);
        rst = 1'b0;

        do_read(4'h0, 32'h0000_0000, "reset DATA");
        do_read(4'h4, 32'h0000_0000, "reset PEND");
        check("reset irq", {31'b0, irq}, 32'd0);

        sw_in = 8'hA5;
        idle(5);
        do_read(4'h0, 32'h0000_0000, "DATA one cycle early");
        do_read(4'h0, 32'h0000_00A5, "DATA after 6 cycles");
        do_read(4'h4, 32'h0000_00A5, "PEND switches");
        do_write(4'h4, 32'h0000_00FF);
        do_read(4'h4, 32'h0000_0000, "PEND cleared");

        key_in = 4'hE;
        idle(3);
        key_in = 4'hF;
        idle(8);
        do_read(4'h0, 32'h0000_00A5, "glitch DATA");
        do_read(4'h4, 32'h0000_0000, "glitch PEND");

        key_in = 4'hE;
        idle(10);
        do_read(4'h0, 32'h0001_00A5, "press DATA");
        do_read(4'h4, 32'h0001_0000, "press PEND");
        key_in = 4'hF;
        idle(10);
        do_read(4'h0, 32'h0000_00A5, "release DATA");
        do_read(4'h4, 32'h0001_0000, "release PEND");

        do_write(4'h8, 32'h0001_0000);
        @(posedge clk); #1;
        check("irq asserted", {31'b0, irq}, 32'd1);
        @(negedge clk);
        do_write(4'h4, 32'h0001_0000);
        check("irq still high at clear edge", {31'b0, irq}, 32'd1);
        @(posedge clk); #1;
        check("irq dropped", {31'b0, irq}, 32'd0);
        @(negedge clk);
        do_read(4'h4, 32'h0000_0000, "PEND after W1C");

        key_in = 4'hE;
        idle(5);
        do_write(4'h4, 32'h0001_0000);
        do_read(4'h4, 32'h0001_0000, "set beats clear");
        check("irq after collision", {31'b0, irq}, 32'd1);
        key_in = 4'hF;
        idle(8);
        do_write(4'h4, MASK);
        do_write(4'h8, 32'h0);

        sw_in = 8'h3C;
        idle(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_read(4'h0, 32'h0000_0000, "DATA after reset");
        idle(4);
        do_read(4'h0, 32'h0000_0000, "DATA before re-accept");
        do_read(4'h0, 32'h0000_003C, "DATA re-accepted");

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) sw_in  = sw_in ^ 8'($urandom);
            if ($urandom_range(0, 19) == 0) key_in = key_in ^ 4'($urandom);
            bus.re    = ($urandom_range(0, 3) == 0);
            bus.we    = ($urandom_range(0, 4) == 0);
            bus.addr  = 4'($urandom);
            bus.wdata = $urandom;
            rst       = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end

        bus.re = 1'b0; bus.we = 1'b0; rst = 1'b0;
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
